// File: rtl/ps2_kb_receiver.sv
// PS/2 keyboard receiver: pin synchronisation, clock deglitch filter,
// 11-bit frame deserialiser, E0/F0 prefix folding and scancode FIFO.
module ps2_kb_receiver #(
   parameter int FIFO_AW    = 3,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk_in,
   input  logic        ps2_data_in,
   input  logic        kb_ack,
   output logic [15:0] kb_data,
   output logic        kb_ready,
   output logic        kb_overflow,
   output logic [7:0]  kb_err_count,
   output logic        kb_busy
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam logic [7:0]      FILT_MAX = 8'(FILTER_LEN - 1);
   localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   logic            clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
   logic [7:0]      filt_cnt_q;
   logic            filt_clk_q, filt_prev_q;
   logic            ev;
   state_t          state_q, state_d;
   logic [2:0]      bitcnt_q;
   logic [7:0]      shreg_q;
   logic            par_q;
   logic [TO_W-1:0] to_cnt_q;
   logic            to_hit;
   logic            frm_vld_q, frm_good_q;
   logic [7:0]      frm_byte_q;
   logic            ext_q, brk_q;
   logic            push, frm_bad;
   logic [15:0]     mem_q [DEPTH];
   logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
   logic            empty, full, pop, wr_en;
   logic [15:0]     wdata, head_d;
   logic [15:0]     kb_data_q;
   logic            kb_ready_q, kb_ovf_q;
   logic [7:0]      err_q;

   // Two-flop synchronisers; the clock pin idles high so its flops reset high
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
      end else begin
         clk_s1_q <= ps2_clk_in;
         clk_s2_q <= clk_s1_q;
      end
      data_s1_q <= ps2_data_in;
      data_s2_q <= data_s1_q;
   end

   // Deglitch: filtered clock follows the synced clock only after FILTER_LEN equal differing samples
   always_ff @(posedge clk) begin
      if (reset) begin
         filt_cnt_q  <= '0;
         filt_clk_q  <= 1'b1;
         filt_prev_q <= 1'b1;
      end else begin
         filt_prev_q <= filt_clk_q;
         if (clk_s2_q == filt_clk_q) begin
            filt_cnt_q <= '0;
         end else if (filt_cnt_q == FILT_MAX) begin
            filt_clk_q <= clk_s2_q;
            filt_cnt_q <= '0;
         end else begin
            filt_cnt_q <= filt_cnt_q + 8'd1;
         end
      end
   end

   assign ev     = filt_prev_q & ~filt_clk_q;
   assign to_hit = (state_q != S_IDLE) && !ev && (to_cnt_q == TO_MAX);

   // Inactivity watchdog, restarted on every sample event and held clear in IDLE
   always_ff @(posedge clk) begin
      if (reset || state_q == S_IDLE || ev || to_hit) to_cnt_q <= '0;
      else                                            to_cnt_q <= to_cnt_q + 1'b1;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state: one transition per filtered falling edge, watchdog forces IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (ev && !data_s2_q) state_d = S_DATA;
         S_DATA:   if (ev && bitcnt_q == 3'd7) state_d = S_PARITY;
         S_PARITY: if (ev) state_d = S_STOP;
         S_STOP:   if (ev) state_d = S_IDLE;
      endcase
      if (to_hit) state_d = S_IDLE;
   end

   // FSM outputs
   always_comb begin
      kb_busy = (state_q != S_IDLE);
   end

   // Bit capture: data bits LSB first, then parity
   always_ff @(posedge clk) begin
      if (ev) begin
         case (state_q)
            S_IDLE: bitcnt_q <= 3'd0;
            S_DATA: begin
               shreg_q[bitcnt_q] <= data_s2_q;
               bitcnt_q          <= bitcnt_q + 3'd1;
            end
            S_PARITY: par_q <= data_s2_q;
            default: ;
         endcase
      end
   end

   // Frame-complete strobe, one cycle after the stop-bit event
   always_ff @(posedge clk) begin
      if (reset) frm_vld_q <= 1'b0;
      else       frm_vld_q <= ev && (state_q == S_STOP);
   end

   // Frame verdict: stop bit high and odd parity over data plus parity bit
   always_ff @(posedge clk) begin
      if (ev && state_q == S_STOP) begin
         frm_good_q <= data_s2_q & (^{shreg_q, par_q});
         frm_byte_q <= shreg_q;
      end
   end

   assign frm_bad = frm_vld_q & ~frm_good_q;
   assign push    = frm_vld_q & frm_good_q & (frm_byte_q != 8'hE0) & (frm_byte_q != 8'hF0);
   assign wdata   = {6'b0, brk_q, ext_q, frm_byte_q};

   // Prefix flags: E0/F0 arm a flag, any pushed byte or error clears both
   always_ff @(posedge clk) begin
      if (reset || to_hit || frm_bad) begin
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else if (frm_vld_q) begin
         if (frm_byte_q == 8'hE0)      ext_q <= 1'b1;
         else if (frm_byte_q == 8'hF0) brk_q <= 1'b1;
         else begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
         end
      end
   end

   // Saturating error counter
   always_ff @(posedge clk) begin
      if (reset)                                err_q <= '0;
      else if ((to_hit || frm_bad) && err_q != 8'hFF) err_q <= err_q + 8'd1;
   end

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
   assign pop      = kb_ack & ~empty;
   assign wr_en    = push & (~full | pop);
   assign wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, wr_en};
   assign rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};

   // Next head entry, bypassing the write when it lands in the new head slot
   always_comb begin
      head_d = mem_q[rd_ptr_d[FIFO_AW-1:0]];
      if (wr_en && wr_ptr_q[FIFO_AW-1:0] == rd_ptr_d[FIFO_AW-1:0]) head_d = wdata;
      if (wr_ptr_d == rd_ptr_d) head_d = '0;
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= wdata;
   end

   // FIFO pointers, registered head/ready outputs and sticky overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         kb_data_q  <= '0;
         kb_ready_q <= 1'b0;
         kb_ovf_q   <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         kb_data_q  <= head_d;
         kb_ready_q <= (wr_ptr_d != rd_ptr_d);
         if (push && full && !pop) kb_ovf_q <= 1'b1;
      end
   end

   assign kb_data      = kb_data_q;
   assign kb_ready     = kb_ready_q;
   assign kb_overflow  = kb_ovf_q;
   assign kb_err_count = err_q;

endmodule

// File: tb/tb_ps2_kb_receiver.sv
// Randomised self-checking bench for ps2_kb_receiver with a queue-based reference model.
module tb_ps2_kb_receiver;

   localparam int FIFO_AW = 3;
   localparam int DEPTH   = 1 << FIFO_AW;
   localparam int FLEN    = 8;
   localparam int TOUT    = 2000;
   localparam int HALF    = 20;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ps2_clk_in = 1'b1;
   logic        ps2_data_in = 1'b1;
   logic        kb_ack = 1'b0;
   logic [15:0] kb_data;
   logic        kb_ready, kb_overflow, kb_busy;
   logic [7:0]  kb_err_count;

   int n_chk = 0;
   int n_err = 0;

   logic [15:0] exp_q[$];
   bit          m_ext, m_brk, m_ovf;
   int          m_err;

   ps2_kb_receiver #(.FIFO_AW(FIFO_AW), .FILTER_LEN(FLEN), .TIMEOUT(TOUT)) dut (
      .clk(clk), .reset(reset), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
      .kb_ack(kb_ack), .kb_data(kb_data), .kb_ready(kb_ready), .kb_overflow(kb_overflow),
      .kb_err_count(kb_err_count), .kb_busy(kb_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic void model_reset();
      exp_q.delete();
      m_ext = 0; m_brk = 0; m_ovf = 0; m_err = 0;
   endfunction

   function automatic void model_bad();
      if (m_err < 255) m_err++;
      m_ext = 0; m_brk = 0;
   endfunction

   function automatic void model_frame(input logic [7:0] b, input bit good);
      if (!good) model_bad();
      else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
         if (exp_q.size() < DEPTH) exp_q.push_back({6'b0, m_brk, m_ext, b});
         else m_ovf = 1;
         m_ext = 0; m_brk = 0;
      end
   endfunction

   function automatic void model_pop();
      if (exp_q.size() > 0) void'(exp_q.pop_front());
   endfunction

   task automatic check_state(input string tag);
      @(negedge clk);
      check({tag, "_ready"}, {31'b0, kb_ready}, {31'b0, exp_q.size() != 0});
      check({tag, "_data"}, {16'b0, kb_data}, (exp_q.size() != 0) ? {16'b0, exp_q[0]} : 32'h0);
      check({tag, "_err"}, {24'b0, kb_err_count}, m_err);
      check({tag, "_ovf"}, {31'b0, kb_overflow}, {31'b0, m_ovf});
      check({tag, "_busy"}, {31'b0, kb_busy}, 32'h0);
      #1;
   endtask

   task automatic pop_one();
      @(negedge clk);
      kb_ack = 1'b1;
      @(posedge clk);
      #1;
      kb_ack = 1'b0;
      model_pop();
   endtask

   // Drives nedge bits of a frame (11 = complete); optional ack in the FIFO write cycle
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int nedge, input bit ack_at_end, input bit chk_lat);
      logic [10:0] bits;
      bit seen;
      seen = 0;
      bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nedge; i++) begin
         ps2_data_in = bits[i];
         tick(HALF);
         ps2_clk_in = 1'b0;
         if (i == 10) begin
            for (int k = 0; k < HALF; k++) begin
               @(negedge clk);
               if (!seen && !kb_busy) begin
                  seen = 1;
                  if (ack_at_end) model_pop();
                  model_frame(b, !bad_par && !bad_stop);
                  if (chk_lat) check("lat_t1_ready", {31'b0, kb_ready}, 32'h0);
                  if (ack_at_end) begin
                     kb_ack = 1'b1;
                     @(posedge clk);
                     #1;
                     kb_ack = 1'b0;
                  end
                  if (chk_lat) begin
                     @(negedge clk);
                     check("lat_t2_ready", {31'b0, kb_ready}, 32'h1);
                     check("lat_t2_data", {16'b0, kb_data}, {16'b0, exp_q[0]});
                  end
               end
            end
            if (!seen) check("frame_end_busy_fall", 32'h0, 32'h1);
            tick(1);
         end else begin
            tick(HALF);
         end
         ps2_clk_in = 1'b1;
      end
      ps2_data_in = 1'b1;
      tick(2 * HALF);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [7:0] b;
      bit bp;
      model_reset();
      tick(4);
      @(negedge clk);
      check("rst_data", {16'b0, kb_data}, 32'h0);
      check("rst_ready", {31'b0, kb_ready}, 32'h0);
      check("rst_ovf", {31'b0, kb_overflow}, 32'h0);
      check("rst_err", {24'b0, kb_err_count}, 32'h0);
      check("rst_busy", {31'b0, kb_busy}, 32'h0);
      reset = 1'b0;
      tick(5);

      // Single frame with latency check, then pop
      send_frame(8'h1C, 0, 0, 11, 0, 1);
      check_state("one");
      pop_one();
      check_state("one_pop");

      // Prefix folding
      send_frame(8'hE0, 0, 0, 11, 0, 0);
      send_frame(8'hF0, 0, 0, 11, 0, 0);
      send_frame(8'h74, 0, 0, 11, 0, 0);
      check_state("pfx");
      check("pfx_val", {16'b0, kb_data}, 32'h0374);
      send_frame(8'h1C, 0, 0, 11, 0, 0);
      pop_one();
      check_state("pfx_clr");
      check("pfx_clr_val", {16'b0, kb_data}, 32'h001C);
      pop_one();

      // Parity and stop errors
      send_frame(8'h1C, 1, 0, 11, 0, 0);
      send_frame(8'h1C, 0, 1, 11, 0, 0);
      check_state("errs");
      check("errs_cnt", {24'b0, kb_err_count}, 32'h2);

      // Overflow and ordering
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 11, 0, 0);
      check_state("ovf");
      for (int i = 0; i < DEPTH; i++) begin
         pop_one();
         check_state("ovf_pop");
      end

      // Full FIFO with simultaneous push and pop
      do_reset();
      for (int i = 1; i <= 8; i++) send_frame(8'(i), 0, 0, 11, 0, 0);
      send_frame(8'h09, 0, 0, 11, 1, 0);
      check_state("fullpp");
      for (int i = 0; i < DEPTH; i++) begin
         pop_one();
         check_state("fullpp_pop");
      end

      // Short clock glitch in IDLE must be rejected
      ps2_data_in = 1'b0;
      ps2_clk_in = 1'b0;
      tick(5);
      ps2_clk_in = 1'b1;
      tick(HALF);
      ps2_data_in = 1'b1;
      check_state("glitch");

      // Partial frame then watchdog abort
      send_frame(8'hA5, 0, 0, 5, 0, 0);
      @(negedge clk);
      check("to_busy_mid", {31'b0, kb_busy}, 32'h1);
      tick(TOUT + 50);
      model_bad();
      check_state("timeout");
      send_frame(8'h2A, 0, 0, 11, 0, 0);
      check_state("after_to");
      pop_one();

      // Randomised traffic
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 9))
            0, 1:    b = 8'hE0;
            2:       b = 8'hF0;
            default: b = 8'($urandom_range(0, 255));
         endcase
         bp = ($urandom_range(0, 9) == 0);
         send_frame(b, bp, 0, 11, 0, 0);
         check_state("rnd");
         if ($urandom_range(0, 1) == 1) begin
            pop_one();
            check_state("rnd_pop");
         end
      end

      // Reset in the middle of a frame with data queued
      do_reset();
      send_frame(8'h55, 0, 0, 11, 0, 0);
      send_frame(8'h33, 0, 0, 6, 0, 0);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      check("mid_rst_data", {16'b0, kb_data}, 32'h0);
      check("mid_rst_ready", {31'b0, kb_ready}, 32'h0);
      check("mid_rst_busy", {31'b0, kb_busy}, 32'h0);
      check("mid_rst_err", {24'b0, kb_err_count}, 32'h0);
      check("mid_rst_ovf", {31'b0, kb_overflow}, 32'h0);
      tick(2);
      send_frame(8'h6B, 0, 0, 11, 0, 0);
      check_state("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
